// File: rtl/decrypt_pkg.sv
// Shared constants and helpers for the ciphertext-to-plaintext decrypt path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package decrypt_pkg;

  // Default XOR key bytes; these must track the encryptor's key bytes.
  localparam logic [7:0] DEF_KEY1 = 8'h12;
  localparam logic [7:0] DEF_KEY2 = 8'h34;
  localparam logic [7:0] DEF_KEY3 = 8'h56;

  // The encryptor scrambles with scrambled[j] = in[PERM[j]].
  // The current table is a plain bit reversal.
  localparam logic [2:0] PERM [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  typedef enum logic {PRIME, RUN} state_e;

  // Rotation order matches the encryptor's low-byte rotation: 0->KEY3, 1->KEY1, 2->KEY2.
  function automatic logic [7:0] key_sel(input logic [1:0] idx,
                                         input logic [7:0] k1,
                                         input logic [7:0] k2,
                                         input logic [7:0] k3);
    logic [7:0] k;
    case (idx)
      2'd0:    k = k3;
      2'd1:    k = k1;
      default: k = k2;
    endcase
    return k;
  endfunction

  // Undo the encryptor's permutation: plain[PERM[j]] = t[j].
  function automatic logic [7:0] unperm(input logic [7:0] t);
    logic [7:0] p;
    p = 8'h00;
    for (int j = 0; j < 8; j++) begin
      p[PERM[j]] = t[j];
    end
    return p;
  endfunction

endpackage

// File: rtl/decrypt_fifo.sv
// Small synchronous byte FIFO holding decoded plaintext.
// Latency: a push is visible at the head one edge later; dout is read combinationally.
// Backpressure: a push is accepted when full only if a pop happens the same edge; otherwise the push is ignored.
module decrypt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] wdat,
  input  logic       pop,
  output logic [7:0] rdat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_pop;
  logic        do_push;

  // The extra pointer bit tells full from empty when the index bits are equal.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdat    = mem_q[rd_q[AW-1:0]];

  // Pointer and storage update; storage is cleared on reset so dout starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= wdat;
        wr_q <= wr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/decrypt_unit.sv
// Decrypts the encryptor's byte stream: XOR with rotating key, inverse permutation, FIFO buffering.
// Latency: byte sampled at edge E0 is written at E1 and is valid at dout during the cycle after E1.
// Backpressure: input has none; a full FIFO without a same-edge pop drops the byte and sets sticky ovf.
module decrypt_unit
  import decrypt_pkg::*;
#(
  parameter logic [7:0] KEY1       = DEF_KEY1,
  parameter logic [7:0] KEY2       = DEF_KEY2,
  parameter logic [7:0] KEY3       = DEF_KEY3,
  parameter bit         DROP_PRIME = 1'b1,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       en,
  input  logic       resync,
  input  logic       rdy,
  output logic [7:0] dout,
  output logic       v,
  output logic       ovf
);

  logic [1:0] key_idx_q;
  logic [1:0] key_idx_d;
  logic [7:0] cin_q;
  logic [7:0] key_q;
  logic       s1_v_q;
  logic       ovf_q;
  logic       ovf_d;
  state_e     state_q;
  state_e     state_d;

  logic       accept;
  logic       wr_req;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] plain;

  // A byte arriving with resync is thrown away and does not consume a key.
  assign accept = en && !resync;
  assign pop    = v && rdy && !resync;
  assign plain  = unperm(cin_q ^ key_q);

  // Key index advances once per accepted byte, including the priming byte.
  always_comb begin
    key_idx_d = key_idx_q;
    if (resync) begin
      key_idx_d = 2'd0;
    end else if (accept) begin
      key_idx_d = (key_idx_q == 2'd2) ? 2'd0 : key_idx_q + 2'd1;
    end
  end

  // FSM next state: the first stage-1 byte after reset/resync is the encryptor's priming byte.
  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    if (s1_v_q) begin
      case (state_q)
        PRIME: begin
          wr_req  = !DROP_PRIME;
          state_d = RUN;
        end
        default: begin
          wr_req = 1'b1;
        end
      endcase
    end
    if (resync) begin
      state_d = PRIME;
      wr_req  = 1'b0;
    end
  end

  // Overflow is sticky: a write that finds the FIFO full with no pop to make room.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage 1 capture, key schedule and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_idx_q <= 2'd0;
      cin_q     <= 8'h00;
      key_q     <= 8'h00;
      s1_v_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      key_idx_q <= key_idx_d;
      s1_v_q    <= accept;
      ovf_q     <= ovf_d;
      if (accept) begin
        cin_q <= din;
        key_q <= key_sel(key_idx_q, KEY1, KEY2, KEY3);
      end
    end
  end

  decrypt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (resync),
    .push  (wr_req),
    .wdat  (plain),
    .pop   (pop),
    .rdat  (dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign v   = !fifo_empty;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_decrypt_unit.sv
// Directed bench for decrypt_unit: priming, backpressure/overflow, full push+pop, resync and reset.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Backpressure: rdy is driven per test to hold or drain the plaintext FIFO.
module tb_decrypt_unit;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       en;
  logic       resync;
  logic       rdy;
  logic [7:0] dout1;
  logic       v1;
  logic       ovf1;
  logic [7:0] dout0;
  logic       v0;
  logic       ovf0;

  int n_cmp = 0;
  int n_err = 0;

  decrypt_unit #(.DROP_PRIME(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .resync(resync), .rdy(rdy),
    .dout(dout1), .v(v1), .ovf(ovf1)
  );

  decrypt_unit #(.DROP_PRIME(1'b0)) dut_np (
    .clk(clk), .rst(rst), .din(din), .en(en), .resync(resync), .rdy(rdy),
    .dout(dout0), .v(v0), .ovf(ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    en  = 1'b1;
    din = b;
    step();
  endtask

  task automatic idle();
    en = 1'b0;
    step();
  endtask

  // 56,90,76,56 after reset/resync decode to (dropped 00),41,42,00.
  task automatic run_prime(input bit chk_np);
    rdy = 1'b1;
    send(8'h56);
    chk_eq("prime_e0_v", v1, 0);
    if (chk_np) chk_eq("np_e0_v", v0, 0);
    send(8'h90);
    chk_eq("prime_e1_v", v1, 0);
    if (chk_np) begin
      chk_eq("np_e1_v", v0, 1);
      chk_eq("np_e1_dout", dout0, 8'h00);
    end
    send(8'h76);
    chk_eq("prime_41_v", v1, 1);
    chk_eq("prime_41_dout", dout1, 8'h41);
    send(8'h56);
    chk_eq("prime_42_v", v1, 1);
    chk_eq("prime_42_dout", dout1, 8'h42);
    idle();
    chk_eq("prime_00_v", v1, 1);
    chk_eq("prime_00_dout", dout1, 8'h00);
    idle();
    chk_eq("prime_end_v", v1, 0);
    chk_eq("prime_ovf", ovf1, 0);
  endtask

  // Plaintexts 01..06 with keys idx1,2,0,1,2,0 -> ciphertext rev(p)^key.
  logic [7:0] drain_exp [5];

  initial begin
    rst    = 1'b1;
    din    = 8'h00;
    en     = 1'b0;
    resync = 1'b0;
    rdy    = 1'b0;
    step();
    step();
    chk_eq("rst_v", v1, 0);
    chk_eq("rst_dout", dout1, 8'h00);
    chk_eq("rst_ovf", ovf1, 0);
    chk_eq("rst_np_v", v0, 0);
    chk_eq("rst_np_ovf", ovf0, 0);
    rst = 1'b0;

    // Priming behaviour for both DROP_PRIME settings.
    run_prime(1'b1);

    // Full FIFO with simultaneous push and pop.
    rst = 1'b1; idle(); rst = 1'b0;
    rdy = 1'b0;
    send(8'h56); send(8'h92); send(8'h74); send(8'h96); send(8'h32); send(8'h94);
    chk_eq("full_head_v", v1, 1);
    chk_eq("full_head_dout", dout1, 8'h01);
    rdy = 1'b1;
    send(8'h36);
    chk_eq("full_pp_dout2", dout1, 8'h02);
    drain_exp = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    for (int i = 0; i < 4; i++) begin
      idle();
      chk_eq($sformatf("full_pp_dout_%0d", i), dout1, {24'h0, drain_exp[i]});
      chk_eq($sformatf("full_pp_v_%0d", i), v1, 1);
    end
    idle();
    chk_eq("full_pp_empty", v1, 0);
    chk_eq("full_pp_ovf", ovf1, 0);

    // Overflow with rdy=0: fifth byte dropped.
    rst = 1'b1; idle(); rst = 1'b0;
    rdy = 1'b0;
    send(8'h56); send(8'h92); send(8'h74); send(8'h96); send(8'h32); send(8'h94);
    chk_eq("ovf_before", ovf1, 0);
    idle();
    chk_eq("ovf_set", ovf1, 1);
    chk_eq("ovf_head", dout1, 8'h01);
    rdy = 1'b1;
    send(8'h5e);
    chk_eq("ovf_drain_02", dout1, 8'h02);
    drain_exp = '{8'h03, 8'h04, 8'h10, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      idle();
      chk_eq($sformatf("ovf_drain_%0d", i), dout1, {24'h0, drain_exp[i]});
      chk_eq($sformatf("ovf_drain_v_%0d", i), v1, 1);
    end
    idle();
    chk_eq("ovf_drain_empty", v1, 0);
    chk_eq("ovf_sticky", ovf1, 1);

    // Resync mid-stream with a concurrent byte.
    rdy = 1'b0;
    send(8'h90);
    send(8'h76);
    chk_eq("rs_pre_v", v1, 1);
    chk_eq("rs_pre_dout", dout1, 8'h41);
    resync = 1'b1;
    send(8'haa);
    resync = 1'b0;
    chk_eq("rs_flush_v", v1, 0);
    chk_eq("rs_ovf_kept", ovf1, 1);
    rdy = 1'b1;
    idle();
    chk_eq("rs_idle_v", v1, 0);
    send(8'h56);
    send(8'h90);
    chk_eq("rs_prime_v", v1, 0);
    idle();
    chk_eq("rs_out_v", v1, 1);
    chk_eq("rs_out_dout", dout1, 8'h41);
    idle();
    chk_eq("rs_out_end", v1, 0);

    // Reset mid-burst with three bytes queued and ovf set.
    rdy = 1'b0;
    send(8'h76);
    send(8'h56);
    send(8'h90);
    idle();
    chk_eq("rb_q_v", v1, 1);
    chk_eq("rb_q_dout", dout1, 8'h42);
    chk_eq("rb_q_ovf", ovf1, 1);
    rst = 1'b1;
    en  = 1'b1;
    din = 8'h90;
    step();
    rst = 1'b0;
    en  = 1'b0;
    chk_eq("rb_v", v1, 0);
    chk_eq("rb_ovf", ovf1, 0);
    chk_eq("rb_dout", dout1, 8'h00);
    run_prime(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
